// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1RW+1R SRAM: FSM state,
// read-latency legality rule and the byte-lane merge.
package sram_pkg;

  typedef enum logic {INIT = 1'b0, READY = 1'b1} init_state_e;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 2;

  // Widest word the merge helper handles; callers cast to their own width.
  localparam int MERGE_MAX_W = 1024;

  function automatic bit read_latency_ok(input int lat);
    return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
  endfunction

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]   old_word,
    input logic [MERGE_MAX_W-1:0]   new_word,
    input logic [MERGE_MAX_W/8-1:0] mask
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_MAX_W/8; i++)
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Zero-initialisation sequencer: walks every address once after reset,
// holding busy high until the last word has been cleared.
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  output logic                  busy,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);

  init_state_e           state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && cnt == '1) state_nxt = READY;
  end

  always_comb begin
    busy      = (state == INIT);
    init_we   = (state == INIT);
    init_addr = cnt;
  end

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R SRAM with zero-init, selectable read latency and
// collision pulse. Define SRAM_BYPASS_EN to forward colliding write data to port 1.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_WMASKS   = DATA_WIDTH/8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dvalid1,
  output logic                  busy,
  output logic                  coll
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int NPORTS    = 2;

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0 || NUM_WMASKS != DATA_WIDTH/8) begin : g_bad_width
    $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of 8 and NUM_WMASKS derived");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  sram_init_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_init (
    .clk0      (clk0),
    .rstb0     (rstb0),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  logic                               wr0, coll_now;
  logic [NPORTS-1:0]                  rd_req;
  logic [NPORTS-1:0][DATA_WIDTH-1:0]  rd_word;
  logic [DATA_WIDTH-1:0]              merged0;

  assign wr0       = !busy && !csb0 && !web0;
  assign rd_req[0] = !busy && !csb0 &&  web0;
  assign rd_req[1] = !busy && !csb1;
  assign coll_now  = wr0 && rd_req[1] && (addr0 == addr1);

  assign merged0 = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(mem[addr0]), MERGE_MAX_W'(din0),
                                          (MERGE_MAX_W/8)'(wmask0)));

  assign rd_word[0] = mem[addr0];
`ifdef SRAM_BYPASS_EN
  assign rd_word[1] = coll_now ? merged0 : mem[addr1];
`else
  assign rd_word[1] = mem[addr1];
`endif

  // Init sequencer owns the write port while busy; user writes are gated off.
  always_ff @(posedge clk0) begin
    if (init_we)  mem[init_addr] <= '0;
    else if (wr0) mem[addr0]     <= merged0;
  end

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) coll <= 1'b0;
    else        coll <= coll_now;
  end

  // Stage s takes its input from stage s-1 (stage 0 from the request); the
  // last stage drives the port, so it holds whenever no read arrives.
  logic [NPORTS-1:0][READ_LATENCY-1:0]                 vld_pipe, vld_in;
  logic [NPORTS-1:0][READ_LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe, dat_in;

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      vld_in[p] = READ_LATENCY'({vld_pipe[p], rd_req[p]});
      dat_in[p] = (READ_LATENCY*DATA_WIDTH)'({dat_pipe[p], rd_word[p]});
    end
  end

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++)
        for (int s = 0; s < READ_LATENCY; s++) begin
          vld_pipe[p][s] <= vld_in[p][s];
          if (vld_in[p][s]) dat_pipe[p][s] <= dat_in[p][s];
        end
    end
  end

  assign dout0   = dat_pipe[0][READ_LATENCY-1];
  assign dvalid0 = vld_pipe[0][READ_LATENCY-1];
  assign dout1   = dat_pipe[1][READ_LATENCY-1];
  assign dvalid1 = vld_pipe[1][READ_LATENCY-1];

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: latency-1 and latency-2 instances share inputs
// and are checked against an array-based model of the memory.
module tb_sram_1rw1r_param;

  localparam int DW = 32, AW = 8, NM = 4, DEPTH = 256, HIST = 8192;
`ifdef SRAM_BYPASS_EN
  localparam logic [DW-1:0] COLL_EXP = 32'h0000FFFF;
`else
  localparam logic [DW-1:0] COLL_EXP = 32'h00000000;
`endif

  logic          clk0 = 1'b0, rstb0 = 1'b1;
  logic          csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [NM-1:0] wmask0 = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] din0 = '0;
  logic [DW-1:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic          dvalid0_a, dvalid1_a, dvalid0_b, dvalid1_b;
  logic          busy_a, busy_b, coll_a, coll_b;

  always #5 clk0 = ~clk0;

  sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_a (
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0_a), .dvalid0(dvalid0_a),
    .csb1(csb1), .addr1(addr1), .dout1(dout1_a), .dvalid1(dvalid1_a),
    .busy(busy_a), .coll(coll_a));

  sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut_b (
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0_b), .dvalid0(dvalid0_b),
    .csb1(csb1), .addr1(addr1), .dout1(dout1_b), .dvalid1(dvalid1_b),
    .busy(busy_b), .coll(coll_b));

  // obs/e arrays indexed [dut: 0=latency1, 1=latency2][port]
  logic [DW-1:0] obs_d [2][2];
  logic          obs_v [2][2];
  assign obs_d[0][0] = dout0_a;  assign obs_v[0][0] = dvalid0_a;
  assign obs_d[0][1] = dout1_a;  assign obs_v[0][1] = dvalid1_a;
  assign obs_d[1][0] = dout0_b;  assign obs_v[1][0] = dvalid0_b;
  assign obs_d[1][1] = dout1_b;  assign obs_v[1][1] = dvalid1_b;

  logic [DW-1:0] mdl [DEPTH];
  int            init_left = DEPTH;
  int            edge_n = 0;
  bit            rq_v [2][HIST];
  logic [DW-1:0] rq_d [2][HIST];
  logic [DW-1:0] e_d [2][2];
  bit            e_v [2][2];
  bit            e_busy, e_coll;
  int            n_cmp = 0, n_bad = 0;

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NM-1:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  // One clock edge: the model consumes the requests on the inputs, the edge
  // happens, and the expected output view after that edge is refreshed.
  task automatic step();
    logic [DW-1:0] merged;
    bit            wr, col;
    int            idx;
    edge_n++;
    rq_v[0][edge_n] = 1'b0;
    rq_v[1][edge_n] = 1'b0;
    col = 1'b0;
    if (init_left == 0) begin
      wr  = !csb0 && !web0;
      col = wr && !csb1 && (addr0 == addr1);
      merged = mdl[addr0];
      for (int i = 0; i < NM; i++) if (wmask0[i]) merged[8*i +: 8] = din0[8*i +: 8];
      if (!csb0 && web0) begin rq_v[0][edge_n] = 1'b1; rq_d[0][edge_n] = mdl[addr0]; end
      if (!csb1) begin
        rq_v[1][edge_n] = 1'b1;
        rq_d[1][edge_n] = mdl[addr1];
`ifdef SRAM_BYPASS_EN
        if (col) rq_d[1][edge_n] = merged;
`endif
      end
      if (wr) mdl[addr0] = merged;
    end else begin
      init_left--;
    end
    @(posedge clk0);
    @(negedge clk0);
    e_busy = (init_left > 0);
    e_coll = col;
    for (int d = 0; d < 2; d++) begin
      idx = edge_n - d;
      for (int p = 0; p < 2; p++) begin
        e_v[d][p] = rq_v[p][idx];
        if (e_v[d][p]) e_d[d][p] = rq_d[p][idx];
      end
    end
  endtask

  task automatic do_reset();
    rstb0 = 1'b0;
    idle();
    rq_v[0][edge_n] = 1'b0;
    rq_v[1][edge_n] = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    init_left = DEPTH;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin e_v[d][p] = 1'b0; e_d[d][p] = '0; end
    e_busy = 1'b1;
    e_coll = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk0);
    @(negedge clk0);
    rstb0 = 1'b1;
  endtask

  task automatic test_reset_init();
    int n;
    bit saw_coll, saw_vld;
    #2;
    do_reset();
    n_cmp++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1 || coll_a !== 1'b0 || coll_b !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: busy=%b/%b coll=%b/%b, want busy=1 coll=0", busy_a, busy_b, coll_a, coll_b);
    end
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        n_cmp++;
        if (obs_v[d][p] !== 1'b0 || obs_d[d][p] !== '0) begin
          n_bad++; $display("FAIL reset_out lat%0d port%0d: v=%b d=%h, want 0/0", d+1, p, obs_v[d][p], obs_d[d][p]);
        end
      end
    release_reset();
    n = 0; saw_coll = 0; saw_vld = 0;
    while (1) begin
      if (n == 10) begin set_wr(8'h03, 32'h5, 4'hF); csb1 = 1'b0; addr1 = 8'h03; end
      else idle();
      step();
      n++;
      if (coll_a || coll_b) saw_coll = 1;
      if (dvalid0_a || dvalid1_a || dvalid0_b || dvalid1_b) saw_vld = 1;
      if (!busy_a || n >= 400) break;
    end
    n_cmp++;
    if (n !== 256) begin n_bad++; $display("FAIL busy_len: %0d edges, want 256", n); end
    n_cmp++;
    if (busy_b !== 1'b0) begin n_bad++; $display("FAIL busy_b_len: busy_b=%b, want 0", busy_b); end
    n_cmp++;
    if (saw_coll || saw_vld) begin n_bad++; $display("FAIL busy_drop: coll=%b dvalid=%b seen, want 0/0", saw_coll, saw_vld); end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h03; csb1 = 1'b0; addr1 = 8'hFF;
    step();
    idle();
    n_cmp++;
    if (dvalid0_a !== 1'b1 || dout0_a !== 32'h0) begin n_bad++; $display("FAIL dropped_write: v=%b d=%h, want 1/00000000", dvalid0_a, dout0_a); end
    n_cmp++;
    if (dvalid1_a !== 1'b1 || dout1_a !== 32'h0 || dvalid1_b !== 1'b0) begin
      n_bad++; $display("FAIL rd_ff_lat1: v=%b d=%h v_b=%b, want 1/00000000/0", dvalid1_a, dout1_a, dvalid1_b);
    end
    step();
    n_cmp++;
    if (dvalid1_b !== 1'b1 || dout1_b !== 32'h0 || dvalid1_a !== 1'b0) begin
      n_bad++; $display("FAIL rd_ff_lat2: v_b=%b d_b=%h v_a=%b, want 1/00000000/0", dvalid1_b, dout1_b, dvalid1_a);
    end
  endtask

  task automatic test_masked_write();
    set_wr(8'h10, 32'hAABBCCDD, 4'hF); step();
    set_wr(8'h10, 32'h11223344, 4'b0101); step();
    idle();
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10; csb1 = 1'b0; addr1 = 8'h10;
    step();
    idle();
    n_cmp++;
    if (dout0_a !== 32'hAA22CC44 || dout1_a !== 32'hAA22CC44 || !dvalid0_a || !dvalid1_a) begin
      n_bad++; $display("FAIL masked_lat1: d0=%h d1=%h, want aa22cc44", dout0_a, dout1_a);
    end
    step();
    n_cmp++;
    if (dout0_b !== 32'hAA22CC44 || dout1_b !== 32'hAA22CC44 || !dvalid0_b || !dvalid1_b) begin
      n_bad++; $display("FAIL masked_lat2: d0=%h d1=%h, want aa22cc44", dout0_b, dout1_b);
    end
  endtask

  task automatic test_latency2();
    set_wr(8'h01, 32'h1, 4'hF); step();
    set_wr(8'h02, 32'h2, 4'hF); step();
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h01; step();
    n_cmp++;
    if (dvalid0_a !== 1'b1 || dout0_a !== 32'h1 || dvalid0_b !== 1'b0) begin
      n_bad++; $display("FAIL b2b_c1: a=%b/%h b_v=%b, want 1/1 0", dvalid0_a, dout0_a, dvalid0_b);
    end
    addr0 = 8'h02; step();
    idle();
    n_cmp++;
    if (dout0_a !== 32'h2 || dvalid0_b !== 1'b1 || dout0_b !== 32'h1) begin
      n_bad++; $display("FAIL b2b_c2: a=%h b=%b/%h, want 2 and 1/1", dout0_a, dvalid0_b, dout0_b);
    end
    step();
    n_cmp++;
    if (dvalid0_a !== 1'b0 || dout0_a !== 32'h2 || dvalid0_b !== 1'b1 || dout0_b !== 32'h2) begin
      n_bad++; $display("FAIL b2b_c3: a=%b/%h b=%b/%h, want 0/2 1/2", dvalid0_a, dout0_a, dvalid0_b, dout0_b);
    end
    step();
    n_cmp++;
    if (dvalid0_b !== 1'b0 || dout0_b !== 32'h2) begin
      n_bad++; $display("FAIL b2b_hold: b=%b/%h, want 0/2", dvalid0_b, dout0_b);
    end
  endtask

  task automatic test_collision();
    set_wr(8'h20, 32'h0, 4'hF); step();
    set_wr(8'h20, 32'hFFFFFFFF, 4'b0011); csb1 = 1'b0; addr1 = 8'h20;
    step();
    idle();
    n_cmp++;
    if (coll_a !== 1'b1 || coll_b !== 1'b1) begin n_bad++; $display("FAIL coll_pulse: %b/%b, want 1/1", coll_a, coll_b); end
    n_cmp++;
    if (dvalid1_a !== 1'b1 || dout1_a !== COLL_EXP) begin n_bad++; $display("FAIL coll_data_lat1: %h, want %h", dout1_a, COLL_EXP); end
    step();
    n_cmp++;
    if (coll_a !== 1'b0 || coll_b !== 1'b0) begin n_bad++; $display("FAIL coll_one_cycle: %b/%b, want 0/0", coll_a, coll_b); end
    n_cmp++;
    if (dvalid1_b !== 1'b1 || dout1_b !== COLL_EXP) begin n_bad++; $display("FAIL coll_data_lat2: %h, want %h", dout1_b, COLL_EXP); end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h20; step();
    n_cmp++;
    if (dout0_a !== 32'h0000FFFF) begin n_bad++; $display("FAIL coll_after: %h, want 0000ffff", dout0_a); end
    set_wr(8'h21, 32'h12345678, 4'hF); csb1 = 1'b0; addr1 = 8'h22;
    step();
    idle();
    n_cmp++;
    if (coll_a !== 1'b0 || dvalid1_a !== 1'b1 || dout1_a !== 32'h0) begin
      n_bad++; $display("FAIL no_coll_diff_addr: coll=%b v=%b d=%h, want 0/1/0", coll_a, dvalid1_a, dout1_a);
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      csb0   = ($urandom_range(0, 2) == 0);
      web0   = $urandom_range(0, 1);
      wmask0 = NM'($urandom);
      addr0  = AW'(8'h40 + $urandom_range(0, 7));
      din0   = $urandom;
      csb1   = ($urandom_range(0, 2) == 0);
      addr1  = AW'(8'h40 + $urandom_range(0, 7));
      step();
      n_cmp++;
      if (busy_a !== e_busy || busy_b !== e_busy || coll_a !== e_coll || coll_b !== e_coll) begin
        n_bad++; $display("FAIL rand_flags c%0d: busy=%b/%b coll=%b/%b, want busy=%b coll=%b", c, busy_a, busy_b, coll_a, coll_b, e_busy, e_coll);
      end
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          n_cmp++;
          if (obs_v[d][p] !== e_v[d][p] || obs_d[d][p] !== e_d[d][p]) begin
            n_bad++; $display("FAIL rand_rd c%0d lat%0d port%0d: v=%b d=%h, want v=%b d=%h", c, d+1, p, obs_v[d][p], obs_d[d][p], e_v[d][p], e_d[d][p]);
          end
        end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int n;
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10; csb1 = 1'b0; addr1 = 8'h10;
    step();
    do_reset();
    n_cmp++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin n_bad++; $display("FAIL mid_reset_busy: %b/%b, want 1/1", busy_a, busy_b); end
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        n_cmp++;
        if (obs_v[d][p] !== 1'b0 || obs_d[d][p] !== '0) begin
          n_bad++; $display("FAIL mid_reset_out lat%0d port%0d: v=%b d=%h, want 0/0", d+1, p, obs_v[d][p], obs_d[d][p]);
        end
      end
    release_reset();
    n = 0;
    while (busy_a && n < 400) begin step(); n++; end
    n_cmp++;
    if (busy_a !== 1'b0 || n !== 256) begin n_bad++; $display("FAIL reinit: busy=%b after %0d edges, want 0 after 256", busy_a, n); end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10;
    step();
    idle();
    n_cmp++;
    if (dvalid0_a !== 1'b1 || dout0_a !== 32'h0) begin n_bad++; $display("FAIL reinit_rd_lat1: v=%b d=%h, want 1/0", dvalid0_a, dout0_a); end
    step();
    n_cmp++;
    if (dvalid0_b !== 1'b1 || dout0_b !== 32'h0) begin n_bad++; $display("FAIL reinit_rd_lat2: v=%b d=%h, want 1/0", dvalid0_b, dout0_b); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset_init();
    test_masked_write();
    test_latency2();
    test_collision();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
